// File: rtl/alu_pkg.sv
// Shared opcode, state and limit definitions for the ALU sequencer
// and the instruction control unit.
package alu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHRA = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_ROR  = 5'd8;
  localparam logic [4:0] OP_ROL  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;

  localparam logic [4:0] LAST_LEGAL_OP = OP_NOT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Folds immediate/memory opcodes onto base ALU ops and
// flags mul/div and illegal opcodes.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [4:0] req_op,
  output logic [4:0] mapped_op,
  output logic       is_muldiv,
  output logic       illegal
);

  // one-hot opcode classification
  always_comb begin
    mapped_op = req_op;
    is_muldiv = 1'b0;
    illegal   = 1'b0;
    unique case (1'b1)
      (req_op > LAST_LEGAL_OP): begin
        illegal   = 1'b1;
        mapped_op = OP_LD;
      end
      (req_op == OP_LDI),
      (req_op == OP_ST),
      (req_op == OP_ADDI): mapped_op = OP_ADD;
      (req_op == OP_ANDI): mapped_op = OP_AND;
      (req_op == OP_ORI):  mapped_op = OP_OR;
      (req_op == OP_MUL),
      (req_op == OP_DIV):  is_muldiv = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issues one ALU op at a time and returns Z via valid/ready.
// Optional mul/div dwell: define ALU_SEQ_MULDIV_STALL_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_hi_valid,
  output logic        rsp_err
);

  if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 16) begin : g_bad_cycles
    $error("MULDIV_CYCLES must be 1..16");
  end

  state_t      state;
  logic [31:0] y_q;
  logic [31:0] b_q;
  logic [63:0] z_q;
  logic        muldiv_q;
  logic [4:0]  mapped_op;
  logic        is_muldiv;
  logic        illegal;
  logic        exec_done;

  alu_op_decode u_dec (
    .req_op    (req_op),
    .mapped_op (mapped_op),
    .is_muldiv (is_muldiv),
    .illegal   (illegal)
  );

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign alu_a     = y_q;
  assign alu_b     = b_q;
  assign rsp_lo    = z_q[31:0];
  assign rsp_hi    = z_q[63:32];

`ifdef ALU_SEQ_MULDIV_STALL_EN
  localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

  logic [3:0] cnt_q;

  assign exec_done = !muldiv_q || (cnt_q == 4'd0);

  // mul/div dwell counter, loaded on accept
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cnt_q <= 4'd0;
    end else if (state == S_IDLE) begin
      cnt_q <= CNT_INIT;
    end else if (state == S_EXEC && !exec_done) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
`else
  assign exec_done = 1'b1;
`endif

  // sequencer FSM with registered operands, opcode and result
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state        <= S_IDLE;
      y_q          <= '0;
      b_q          <= '0;
      z_q          <= '0;
      alu_op       <= OP_LD;
      muldiv_q     <= 1'b0;
      rsp_hi_valid <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              z_q          <= '0;
              rsp_err      <= 1'b1;
              rsp_hi_valid <= 1'b0;
              state        <= S_RESP;
            end else begin
              y_q      <= req_a;
              b_q      <= req_b;
              alu_op   <= mapped_op;
              muldiv_q <= is_muldiv;
              rsp_err  <= 1'b0;
              state    <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            z_q          <= alu_c;
            rsp_hi_valid <= muldiv_q;
            alu_op       <= OP_LD;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_err      <= 1'b0;
            rsp_hi_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a small
// behavioural ALU driving alu_c.
module tb_alu_sequencer;

`ifdef ALU_SEQ_MULDIV_STALL_EN
  localparam int MULLAT = 4;
`else
  localparam int MULLAT = 1;
`endif

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        hv;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_c;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hi_valid;
  logic        rsp_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_sequencer #(.MULDIV_CYCLES(4)) dut (
    .clk          (clk),
    .clear_n      (clear_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c        (alu_c),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_lo       (rsp_lo),
    .rsp_hi       (rsp_hi),
    .rsp_hi_valid (rsp_hi_valid),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // external ALU model: 32-bit results zero-extended
  always_comb begin
    alu_c = {32'd0, alu_a};
    case (alu_op)
      5'd3:  alu_c = {32'd0, alu_a + alu_b};
      5'd4:  alu_c = {32'd0, alu_a - alu_b};
      5'd10: alu_c = {32'd0, alu_a & alu_b};
      5'd11: alu_c = {32'd0, alu_a | alu_b};
      5'd15: alu_c = 64'(alu_a) * 64'(alu_b);
      5'd16: alu_c = (alu_b == 0) ? 64'd0 :
                     {alu_a % alu_b, alu_a / alu_b};
      default: ;
    endcase
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // monitor: compare each handshaken response to the queue
  always @(negedge clk) begin
    if (clear_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_lo", 64'(rsp_lo), 64'(e.lo));
        chk("rsp_hi", 64'(rsp_hi), 64'(e.hi));
        chk("rsp_hi_valid", 64'(rsp_hi_valid), 64'(e.hv));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  task automatic issue(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] exp_op,
                       input int lat,
                       input int hold,
                       input exp_t e);
    int n;
    logic [31:0] lo0, hi0;
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    sb.push_back(e);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 5'd3;
    req_a = 32'hDEAD_BEEF;
    req_b = 32'h1234_5678;
    n = 0;
    while (!rsp_valid && n < 40) begin
      if (n == 0) chk("alu_op_exec", 64'(alu_op), 64'(exp_op));
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("alu_op_resp", 64'(alu_op), 64'd0);
    for (int k = 0; k < hold; k++) begin
      lo0 = rsp_lo;
      hi0 = rsp_hi;
      @(posedge clk);
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_stable", {rsp_hi, rsp_lo}, {hi0, lo0});
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("ready_after_hs", 64'(req_ready), 64'd1);
    chk("valid_after_hs", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_outs", {27'd0, alu_op, alu_a, rsp_lo},
        {27'd0, 5'd0, 32'd0, 32'd0});
    @(negedge clk);
    clear_n = 1'b1;

    issue(5'd3, 32'd5, 32'd7, 5'd3, 1, 0,
          '{lo: 32'd12, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd15, 32'h0001_0000, 32'h0001_0000, 5'd15,
          MULLAT, 0,
          '{lo: 32'd0, hi: 32'd1, hv: 1'b1, err: 1'b0});
    issue(5'd12, 32'hFFFF_FFFF, 32'd1, 5'd3, 1, 0,
          '{lo: 32'd0, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd25, 32'd9, 32'd9, 5'd0, 0, 0,
          '{lo: 32'd0, hi: 32'd0, hv: 1'b0, err: 1'b1});
    issue(5'd4, 32'd20, 32'd3, 5'd4, 1, 3,
          '{lo: 32'd17, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd13, 32'h0000_F0F0, 32'h0000_00FF, 5'd10, 1, 0,
          '{lo: 32'h0000_00F0, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd14, 32'h0000_F000, 32'h0000_000F, 5'd11, 1, 0,
          '{lo: 32'h0000_F00F, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd16, 32'd100, 32'd7, 5'd16, MULLAT, 0,
          '{lo: 32'd14, hi: 32'd2, hv: 1'b1, err: 1'b0});
    issue(5'd0, 32'h0BAD_CAFE, 32'd1, 5'd0, 1, 0,
          '{lo: 32'h0BAD_CAFE, hi: 32'd0, hv: 1'b0, err: 1'b0});
    issue(5'd31, 32'd1, 32'd1, 5'd0, 0, 1,
          '{lo: 32'd0, hi: 32'd0, hv: 1'b0, err: 1'b1});

    // reset in the middle of a div
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 5'd16;
    req_a = 32'd100;
    req_b = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_in_exec", 64'(alu_op), 64'd16);
    clear_n = 1'b0;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_valid", 64'(rsp_valid), 64'd0);
    chk("abort_regs", {alu_a, alu_b}, 64'd0);
    chk("abort_z", {rsp_hi, rsp_lo}, 64'd0);
    chk("abort_flags", {59'd0, alu_op, rsp_err, rsp_hi_valid},
        64'd0);
    @(negedge clk);
    clear_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    chk("abort_ready_after", 64'(req_ready), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
